scarv_cop_palu_multiplier: RTL and testbench
============================================

Name: scarv_cop_palu_multiplier

Overview:
Multi-cycle packed shift-and-add multiplier for the packed ALU. It shares the lane model of the packed adder: 1×32, 2×16, 4×8, 8×4 or 16×2-bit lanes, selected by the `pw` field. Each lane produces its 2W-bit product, and the caller selects the low or high W bits per lane. It sits beside the packed adder inside the PALU, takes operands from the COP register-read stage, and returns its result to the PALU writeback mux through a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported; other values are an elaboration error.

Ports:
- g_clk  in  1  clock.
- g_reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- rs1  in  32  multiplicand, packed.
- rs2  in  32  multiplier, packed.
- pw  in  3  pack width; SCARV_COP_PW_* encoding.
- high  in  1  0: low W bits of each lane product; 1: high W bits.
- flush  in  1  synchronous abort.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  32  packed per-lane product half.

Behaviour:
- Clock and reset: one clock, g_clk. Reset g_reset is asynchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, all internal registers 0.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid, latch pw, high and rs1 into `a`; load acc_lo←rs2, acc_hi←0, cnt←W−1; go to RUN.
    - An invalid pw is still accepted: result=0, go straight to DONE (1-cycle latency).
  - RUN: one step per cycle, all lanes in parallel.
    - Per lane L, sum_L = acc_hi_L + (acc_lo_L[0] ? a_L : 0).
    - The sum is formed by lane-masked addition with no carry across lane boundaries.
    - Lane carry c_L = maj(x_t, y_t, s_t^x_t^y_t), taken at the lane's top bit t.
    - Then, per lane: {acc_hi_L, acc_lo_L} ← {c_L, sum_L, acc_lo_L} >> 1 (W-bit halves).
    - cnt decrements; when cnt==0, take the step and go to DONE.
    - in_ready=0 throughout.
  - DONE:
    - out_valid=1; result = high ? acc_hi : acc_lo.
    - result is held stable while out_valid && !out_ready.
    - On out_ready: go to IDLE, out_valid=0.
- Latency: accept→out_valid = W+1 cycles (W = 32/16/8/4/2).
- Throughput:
  - No overlap; in_ready is low in RUN and DONE.
  - A new accept is possible the cycle after the result handshake.
- flush:
  - From any state, the next state is IDLE with out_valid=0.
  - flush has priority over in_valid in the same cycle; that request is not accepted.
- Arithmetic:
  - Unsigned only.
  - Lanes are fully independent; no bit of lane L affects lane L±1.
  - The result is exact modulo 2^(2W) per lane.
- Reset asserted mid-RUN or mid-DONE: immediate return to the reset values. No partial result is ever presented.
- pw and high are sampled only at accept; changes on these inputs during RUN are ignored.

Decomposition:
- Shared constants: SCARV_COP_PW_* stay in scarv_cop_common.vh.
- Add to scarv_cop_common.vh:
  - state encodings SCARV_COP_PMUL_IDLE, _RUN, _DONE;
  - a lane-width function pw→W for the step counter.
- Sub-module scarv_cop_palu_adder instance:
  - Performs the lane-masked acc_hi + a addition, with ci=0 and sub=0.
  - Lane carries are rebuilt from its operands and sum at the lane top bits; they are not taken from co.
- Shift network and counter stay in this module.

Test Plan:
- pw_1, rs1=0x0000FFFF, rs2=0x00010001, high=0 → result 0xFFFFFFFF, out_valid 33 cycles after accept. With high=1 → 0x00000000.
- pw_2, rs1=0xFFFF0003, rs2=0xFFFF0005 → low=0x0001000F, high=0xFFFE0000, latency 17.
- pw_4, rs1=0x10FF0203, rs2=0x100FFF05 → low=0x00F1FE0F, high=0x010E0100, latency 9.
- pw_16, rs1=rs2=0xFFFFFFFF → low=0x55555555, high=0xAAAAAAAA, latency 3.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result and out_valid stable, in_ready=0. Then out_ready=1 → IDLE next cycle, new accept the cycle after.
- Abort: flush at RUN cycle 3, and async g_reset pulse mid-RUN. For each → IDLE, out_valid never asserts for the aborted op. A following pw_8 op, rs1=0xFFFFFFFF, rs2=0x11111111 → low=0xFFFFFFFF, high=0x00000000.

Source files
------------

// File: rtl/scarv_cop_palu_multiplier_pkg.sv
// Shared packed-ALU constants: pack-width encodings, multiplier state encodings
// and lane-geometry helpers used by the multiplier and its lane-masked adder.
package scarv_cop_palu_multiplier_pkg;

  localparam logic [2:0] SCARV_COP_PW_1  = 3'b001;
  localparam logic [2:0] SCARV_COP_PW_2  = 3'b010;
  localparam logic [2:0] SCARV_COP_PW_4  = 3'b011;
  localparam logic [2:0] SCARV_COP_PW_8  = 3'b100;
  localparam logic [2:0] SCARV_COP_PW_16 = 3'b101;

  localparam logic [1:0] SCARV_COP_PMUL_IDLE = 2'd0;
  localparam logic [1:0] SCARV_COP_PMUL_RUN  = 2'd1;
  localparam logic [1:0] SCARV_COP_PMUL_DONE = 2'd2;

  // Lane width W for a pack-width code; 0 marks an unsupported code.
  function automatic logic [5:0] scarv_cop_pw_lane_width(input logic [2:0] pw);
    case (pw)
      SCARV_COP_PW_1:  scarv_cop_pw_lane_width = 6'd32;
      SCARV_COP_PW_2:  scarv_cop_pw_lane_width = 6'd16;
      SCARV_COP_PW_4:  scarv_cop_pw_lane_width = 6'd8;
      SCARV_COP_PW_8:  scarv_cop_pw_lane_width = 6'd4;
      SCARV_COP_PW_16: scarv_cop_pw_lane_width = 6'd2;
      default:         scarv_cop_pw_lane_width = 6'd0;
    endcase
  endfunction

  function automatic logic [31:0] scarv_cop_pw_lane_start(input logic [2:0] pw);
    case (pw)
      SCARV_COP_PW_1:  scarv_cop_pw_lane_start = 32'h0000_0001;
      SCARV_COP_PW_2:  scarv_cop_pw_lane_start = 32'h0001_0001;
      SCARV_COP_PW_4:  scarv_cop_pw_lane_start = 32'h0101_0101;
      SCARV_COP_PW_8:  scarv_cop_pw_lane_start = 32'h1111_1111;
      SCARV_COP_PW_16: scarv_cop_pw_lane_start = 32'h5555_5555;
      default:         scarv_cop_pw_lane_start = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/scarv_cop_palu_adder.sv
// Lane-masked packed adder/subtractor: a ripple chain whose carry is cut and
// re-seeded with ci|sub at every lane start bit.
module scarv_cop_palu_adder
  import scarv_cop_palu_multiplier_pkg::*;
(
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic [2:0]  pw,
  input  logic        ci,
  input  logic        sub,
  output logic [31:0] result
);

  logic [31:0] start_s;
  logic [31:0] rhs_s;
  logic        carry_s;
  logic        cin_s;

  always_comb begin
    start_s = scarv_cop_pw_lane_start(pw);
    rhs_s   = sub ? ~rhs : rhs;
    carry_s = 1'b0;
    cin_s   = 1'b0;
    result  = 32'd0;
    for (int i = 0; i < 32; i++) begin
      cin_s     = start_s[i] ? (ci | sub) : carry_s;
      result[i] = lhs[i] ^ rhs_s[i] ^ cin_s;
      carry_s   = (lhs[i] & rhs_s[i]) | (cin_s & (lhs[i] ^ rhs_s[i]));
    end
  end

endmodule

// File: rtl/scarv_cop_palu_multiplier.sv
// Multi-cycle packed shift-and-add multiplier: every lane retires one multiplier
// bit per cycle, returning the low or high half of each lane product.
module scarv_cop_palu_multiplier
  import scarv_cop_palu_multiplier_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      pw,
  input  logic            high,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  if (XLEN != 32) begin : g_xlen_unsupported
    $error("scarv_cop_palu_multiplier supports XLEN=32 only");
  end

  logic [1:0]  state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  pw_q, pw_d;
  logic        high_q, high_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;

  logic [31:0] start_s, top_s, addend_s, sum_s, carry_s, lsb_top_s;
  logic [31:0] hi_step_s, lo_step_s;
  logic [5:0]  lane_w_s, in_lane_w_s;
  logic        lane_sel_s;

  assign in_lane_w_s = scarv_cop_pw_lane_width(pw);

  // Addend per lane is either the whole multiplicand lane or zero, chosen by that lane's multiplier LSB.
  always_comb begin
    start_s    = scarv_cop_pw_lane_start(pw_q);
    top_s      = {1'b1, start_s[31:1]};
    lane_w_s   = scarv_cop_pw_lane_width(pw_q);
    lane_sel_s = 1'b0;
    addend_s   = 32'd0;
    for (int i = 0; i < 32; i++) begin
      lane_sel_s  = start_s[i] ? acc_lo_q[i] : lane_sel_s;
      addend_s[i] = a_q[i] & lane_sel_s;
    end
  end

  scarv_cop_palu_adder u_adder (
    .lhs    (acc_hi_q),
    .rhs    (addend_s),
    .pw     (pw_q),
    .ci     (1'b0),
    .sub    (1'b0),
    .result (sum_s)
  );

  // Lane carry-out is rebuilt as maj(x, y, carry-in) only where a lane top bit uses it.
  always_comb begin
    carry_s   = (acc_hi_q & addend_s) | ((acc_hi_q ^ addend_s) & (sum_s ^ acc_hi_q ^ addend_s));
    lsb_top_s = (sum_s & start_s) << (lane_w_s - 6'd1);
    hi_step_s = (top_s & carry_s) | (~top_s & (sum_s >> 1));
    lo_step_s = (top_s & lsb_top_s) | (~top_s & (acc_lo_q >> 1));
  end

  // Next-state logic: accept, step, present and abort.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    acc_lo_d    = acc_lo_q;
    acc_hi_d    = acc_hi_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    pw_d        = pw_q;
    high_d      = high_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      state_d     = SCARV_COP_PMUL_IDLE;
      out_valid_d = 1'b0;
      result_d    = 32'd0;
    end else begin
      case (state_q)
        SCARV_COP_PMUL_IDLE: begin
          if (in_valid) begin
            a_d      = rs1;
            pw_d     = pw;
            high_d   = high;
            acc_hi_d = 32'd0;
            if (in_lane_w_s != 6'd0) begin
              acc_lo_d = rs2;
              cnt_d    = 5'(in_lane_w_s - 6'd1);
              state_d  = SCARV_COP_PMUL_RUN;
            end else begin
              acc_lo_d    = 32'd0;
              cnt_d       = 5'd0;
              result_d    = 32'd0;
              out_valid_d = 1'b1;
              state_d     = SCARV_COP_PMUL_DONE;
            end
          end else begin
            state_d = SCARV_COP_PMUL_IDLE;
          end
        end
        SCARV_COP_PMUL_RUN: begin
          acc_hi_d = hi_step_s;
          acc_lo_d = lo_step_s;
          if (cnt_q == 5'd0) begin
            result_d    = high_q ? hi_step_s : lo_step_s;
            out_valid_d = 1'b1;
            state_d     = SCARV_COP_PMUL_DONE;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        SCARV_COP_PMUL_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            result_d    = 32'd0;
            state_d     = SCARV_COP_PMUL_IDLE;
          end else begin
            state_d = SCARV_COP_PMUL_DONE;
          end
        end
        default: begin
          out_valid_d = 1'b0;
          result_d    = 32'd0;
          state_d     = SCARV_COP_PMUL_IDLE;
        end
      endcase
    end
    in_ready_d = (state_d == SCARV_COP_PMUL_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q     <= SCARV_COP_PMUL_IDLE;
      a_q         <= 32'd0;
      acc_lo_q    <= 32'd0;
      acc_hi_q    <= 32'd0;
      result_q    <= 32'd0;
      cnt_q       <= 5'd0;
      pw_q        <= 3'd0;
      high_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      acc_lo_q    <= acc_lo_d;
      acc_hi_q    <= acc_hi_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      pw_q        <= pw_d;
      high_q      <= high_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_scarv_cop_palu_multiplier.sv
// Scoreboard bench for the packed multiplier: expected products are queued at
// accept and compared when the result handshake arrives.
module tb_scarv_cop_palu_multiplier;

  localparam logic [2:0] PW_1  = 3'b001;
  localparam logic [2:0] PW_2  = 3'b010;
  localparam logic [2:0] PW_4  = 3'b011;
  localparam logic [2:0] PW_8  = 3'b100;
  localparam logic [2:0] PW_16 = 3'b101;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  pw;
  logic        high;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  scarv_cop_palu_multiplier #(.XLEN(32)) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .pw        (pw),
    .high      (high),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 g_clk = ~g_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input logic [2:0] p);
    case (p)
      PW_1:    return 32;
      PW_2:    return 16;
      PW_4:    return 8;
      PW_8:    return 4;
      PW_16:   return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] p, input logic h);
    int w;
    logic [31:0] r;
    logic [63:0] m, x, y, pr;
    w = width_of(p);
    r = 32'd0;
    if (w == 0) return 32'd0;
    m = (64'd1 << w) - 64'd1;
    for (int l = 0; l < 32 / w; l++) begin
      x  = ({32'd0, a} >> (l * w)) & m;
      y  = ({32'd0, b} >> (l * w)) & m;
      pr = x * y;
      if (h) pr = pr >> w;
      r  = r | 32'((pr & m) << (l * w));
    end
    return r;
  endfunction

  // Entered at #1 after an edge with the DUT idle; returns #1 after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] p,
                       input logic h, input bit expect_out, input logic [31:0] exp);
    check_val("in_ready_idle", {31'd0, in_ready}, 32'd1);
    rs1 = a; rs2 = b; pw = p; high = h; in_valid = 1'b1;
    @(posedge g_clk); #1;
    in_valid = 1'b0; rs1 = ~a; rs2 = ~b; pw = ~p; high = ~h;
    if (expect_out) begin
      exp_q.push_back(exp);
      lat_q.push_back(width_of(p) + 1);
    end
  endtask

  task automatic collect(input int stall);
    int cyc;
    logic [31:0] held;
    logic [31:0] exp;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge g_clk); #1;
      cyc++;
    end
    check_val("latency", cyc, lat_q.pop_front());
    exp = exp_q.pop_front();
    check_val("result", result, exp);
    check_val("in_ready_done", {31'd0, in_ready}, 32'd0);
    held = result;
    for (int s = 0; s < stall; s++) begin
      @(posedge g_clk); #1;
      check_val("stall_valid", {31'd0, out_valid}, 32'd1);
      check_val("stall_result", result, held);
      check_val("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge g_clk); #1;
    out_ready = 1'b0;
    check_val("post_hs_valid", {31'd0, out_valid}, 32'd0);
    check_val("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic watch_quiet(input string tag);
    int seen;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge g_clk); #1;
      if (out_valid) seen++;
    end
    check_val(tag, seen, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, e;
    logic [2:0]  p;
    logic        h;
    g_reset = 1'b1; in_valid = 1'b0; rs1 = 32'd0; rs2 = 32'd0; pw = 3'd0;
    high = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_result", result, 32'd0);
    g_reset = 1'b0;
    @(posedge g_clk); #1;

    issue(32'h0000FFFF, 32'h00010001, PW_1, 1'b0, 1'b1, 32'hFFFFFFFF);  collect(0);
    issue(32'h0000FFFF, 32'h00010001, PW_1, 1'b1, 1'b1, 32'h00000000);  collect(0);
    issue(32'hFFFF0003, 32'hFFFF0005, PW_2, 1'b0, 1'b1, 32'h0001000F);  collect(0);
    issue(32'hFFFF0003, 32'hFFFF0005, PW_2, 1'b1, 1'b1, 32'hFFFE0000);  collect(0);
    issue(32'h10FF0203, 32'h100FFF05, PW_4, 1'b0, 1'b1, 32'h00F1FE0F);  collect(0);
    issue(32'h10FF0203, 32'h100FFF05, PW_4, 1'b1, 1'b1, 32'h010E0100);  collect(5);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, PW_16, 1'b0, 1'b1, 32'h55555555); collect(0);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, PW_16, 1'b1, 1'b1, 32'hAAAAAAAA); collect(0);
    issue(32'h12345678, 32'h9ABCDEF0, 3'b000, 1'b0, 1'b1, 32'h00000000); collect(1);
    issue(32'h12345678, 32'h9ABCDEF0, 3'b111, 1'b1, 1'b1, 32'h00000000); collect(0);

    // Flush on the third RUN cycle.
    issue(32'h0000FFFF, 32'h00010001, PW_1, 1'b0, 1'b0, 32'd0);
    repeat (2) begin @(posedge g_clk); #1; end
    flush = 1'b1;
    @(posedge g_clk); #1;
    flush = 1'b0;
    check_val("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("flush_out_valid", {31'd0, out_valid}, 32'd0);
    watch_quiet("flush_quiet");
    issue(32'hFFFFFFFF, 32'h11111111, PW_8, 1'b0, 1'b1, 32'hFFFFFFFF);  collect(0);
    issue(32'hFFFFFFFF, 32'h11111111, PW_8, 1'b1, 1'b1, 32'h00000000);  collect(0);

    // Asynchronous reset pulse in the middle of RUN.
    issue(32'hFFFF0003, 32'hFFFF0005, PW_2, 1'b0, 1'b0, 32'd0);
    repeat (3) begin @(posedge g_clk); #1; end
    #2 g_reset = 1'b1;
    #1;
    check_val("areset_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("areset_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("areset_result", result, 32'd0);
    #2 g_reset = 1'b0;
    @(posedge g_clk); #1;
    watch_quiet("areset_quiet");
    issue(32'hFFFFFFFF, 32'h11111111, PW_8, 1'b0, 1'b1, 32'hFFFFFFFF);  collect(0);

    // flush wins over a same-cycle request.
    rs1 = 32'h5; rs2 = 32'h7; pw = PW_4; in_valid = 1'b1; flush = 1'b1;
    @(posedge g_clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check_val("flush_prio_in_ready", {31'd0, in_ready}, 32'd1);
    watch_quiet("flush_prio_quiet");

    for (int r = 0; r < 10; r++) begin
      a = $urandom;
      b = $urandom;
      p = 3'($urandom_range(0, 7));
      h = 1'($urandom_range(0, 1));
      e = model(a, b, p, h);
      issue(a, b, p, h, 1'b1, e);
      collect($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
